// File: rtl/tata_pkg.sv
// rtl/tata_pkg.sv - shared TAPU types: output mode encoding and the default z row shape.
package tata_pkg;

  localparam int TAPU_COLS         = 16;
  localparam int TAPU_BOTTOM_WIDTH = 48;

  typedef enum logic [1:0] {
    MODE_MATMUL = 2'b00,
    MODE_FPMUL  = 2'b10,
    MODE_FPADD  = 2'b11
  } mode_sel_e;

  typedef logic [TAPU_COLS-1:0][TAPU_BOTTOM_WIDTH-1:0] z_row_t;

endpackage

// File: rtl/delay_chain.sv
// rtl/delay_chain.sv - fixed-length register delay line, LEN >= 1 cycles.
module delay_chain #(
  parameter int WIDTH = 8,
  parameter int LEN   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sr [LEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LEN; i++) r_sr[i] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < LEN; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[LEN-1];

endmodule

// File: rtl/tapu_drain_fifo.sv
// rtl/tapu_drain_fifo.sv - sync row FIFO; a write is accepted while full if a read happens the same cycle.
module tapu_drain_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_wr_en,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_rd_en,
  output logic [W-1:0]  o_rd_data,
  output logic          o_empty,
  output logic          o_full,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_wr;
  logic          w_rd;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign w_rd      = i_rd_en && !o_empty && !i_clr;
  assign w_wr      = i_wr_en && (!o_full || w_rd) && !i_clr;
  // Data is forced to zero while empty so the bus never shows stale rows.
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_wr && !w_rd)      r_count <= r_count + CW'(1);
      else if (w_rd && !w_wr) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/tapu_drain.sv
// rtl/tapu_drain.sv - TAPU column-stripe drain: deskew, row FIFO, tiled output stream.
// Optional TAPU_DRAIN_DROP_CNT_EN adds a saturating dropped-row counter port.
module tapu_drain
  import tata_pkg::*;
#(
  parameter int COLS          = 16,
  parameter int BOTTOM_WIDTH  = 48,
  parameter int FIFO_DEPTH    = 8,
  parameter int ROWS_PER_TILE = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   mode_sel_in,
  input  logic                         clr_in,
  input  logic                         z_valid_in,
  input  logic [COLS*BOTTOM_WIDTH-1:0] z_in,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [COLS*BOTTOM_WIDTH-1:0] m_data,
  output logic                         m_last,
  output logic                         busy_out,
  output logic                         ovf_err
`ifdef TAPU_DRAIN_DROP_CNT_EN
  ,
  output logic [15:0]                  drop_cnt_out
`endif
);

  localparam int VW  = COLS - 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int RCW = (ROWS_PER_TILE > 1) ? $clog2(ROWS_PER_TILE) : 1;

  typedef logic [COLS-1:0][BOTTOM_WIDTH-1:0] row_t;

  row_t           w_z;
  row_t           w_dly;
  row_t           w_row;
  logic           w_matmul;
  logic           w_row_vld;
  logic           w_rd;
  logic           w_full;
  logic           w_empty;
  logic           w_drop;
  logic [CW-1:0]  w_count;
  logic [VW-1:0]  r_vld_sr;
  logic [RCW-1:0] r_row_cnt;
  logic           r_ovf;

  assign w_z      = z_in;
  // Reserved mode 01 falls through to the unskewed path.
  assign w_matmul = (mode_sel_in == MODE_MATMUL);

  for (genvar c = 0; c < COLS; c++) begin : g_col
    if (c == COLS - 1) begin : g_pass
      assign w_dly[c] = w_z[c];
    end else begin : g_dly
      delay_chain #(.WIDTH(BOTTOM_WIDTH), .LEN(COLS - 1 - c)) u_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .i_d  (w_z[c]),
        .o_q  (w_dly[c])
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_vld_sr <= '0;
    else if (clr_in) r_vld_sr <= '0;
    else             r_vld_sr <= (r_vld_sr << 1) | VW'(z_valid_in && w_matmul);
  end

  assign w_row     = w_matmul ? w_dly : w_z;
  assign w_row_vld = w_matmul ? r_vld_sr[VW-1] : z_valid_in;
  assign m_valid   = !w_empty;
  assign w_rd      = m_valid && m_ready;
  assign w_drop    = w_row_vld && w_full && !w_rd && !clr_in;

  tapu_drain_fifo #(.W(COLS * BOTTOM_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (clr_in),
    .i_wr_en  (w_row_vld),
    .i_wr_data(w_row),
    .i_rd_en  (w_rd),
    .o_rd_data(m_data),
    .o_empty  (w_empty),
    .o_full   (w_full),
    .o_count  (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_cnt <= '0;
      r_ovf     <= 1'b0;
    end else if (clr_in) begin
      r_row_cnt <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_rd) r_row_cnt <= (r_row_cnt == RCW'(ROWS_PER_TILE - 1)) ? '0 : r_row_cnt + RCW'(1);
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign m_last   = m_valid && (r_row_cnt == RCW'(ROWS_PER_TILE - 1));
  assign busy_out = (|r_vld_sr) || (w_count != '0);
  assign ovf_err  = r_ovf;

`ifdef TAPU_DRAIN_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_drop_cnt <= '0;
    else if (clr_in)                           r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign drop_cnt_out = r_drop_cnt;
`endif

endmodule

// File: tb/tb_tapu_drain.sv
// tb/tb_tapu_drain.sv - directed bench for tapu_drain with COLS=4, 8-bit elements, 4 rows per tile.
module tb_tapu_drain;

  localparam int COLS  = 4;
  localparam int BW    = 8;
  localparam int DEPTH = 8;
  localparam int RPT   = 4;

  typedef logic [COLS-1:0][BW-1:0] row_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       mode_sel_in;
  logic             clr_in;
  logic             z_valid_in;
  logic [COLS*BW-1:0] z_in;
  logic             m_valid;
  logic             m_ready;
  logic [COLS*BW-1:0] m_data;
  logic             m_last;
  logic             busy_out;
  logic             ovf_err;
`ifdef TAPU_DRAIN_DROP_CNT_EN
  logic [15:0]      drop_cnt_out;
`endif

  row_t hist [COLS];
  int   errors = 0;
  int   checks = 0;
  int   seen;

  always #5 clk = ~clk;

  tapu_drain #(
    .COLS(COLS), .BOTTOM_WIDTH(BW), .FIFO_DEPTH(DEPTH), .ROWS_PER_TILE(RPT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_sel_in(mode_sel_in),
    .clr_in     (clr_in),
    .z_valid_in (z_valid_in),
    .z_in       (z_in),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy_out   (busy_out),
    .ovf_err    (ovf_err)
`ifdef TAPU_DRAIN_DROP_CNT_EN
    ,
    .drop_cnt_out(drop_cnt_out)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic row_t mk(input logic [7:0] base);
    row_t r;
    for (int c = 0; c < COLS; c++) r[c] = base + 8'(c);
    return r;
  endfunction

  // One clock of stimulus; in matmul mode column c carries the row issued c cycles earlier.
  task automatic cycle(input logic vld, input row_t row);
    row_t zr;
    for (int c = COLS - 1; c > 0; c--) hist[c] = hist[c-1];
    hist[0] = row;
    if (mode_sel_in == 2'b00) begin
      for (int c = 0; c < COLS; c++) zr[c] = hist[c][c];
    end else begin
      zr = row;
    end
    z_in       = zr;
    z_valid_in = vld;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr_in = 1'b1;
    cycle(1'b0, '0);
    clr_in = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < COLS; c++) hist[c] = '0;
    rst_n = 1'b0; clr_in = 1'b0; z_valid_in = 1'b0; z_in = '0;
    m_ready = 1'b1; mode_sel_in = 2'b00;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy_out, 0);
    check("rst_ovf", ovf_err, 0);
    check("rst_m_data", m_data, 0);

    // Matmul single row: column c = 0x10+c, skewed in; row appears COLS cycles later.
    cycle(1'b1, mk(8'h10));
    check("t1_busy", busy_out, 1);
    for (int k = 1; k <= 2; k++) begin
      check("t1_early", m_valid, 0);
      cycle(1'b0, '0);
    end
    check("t1_early3", m_valid, 0);
    cycle(1'b0, '0);
    check("t1_valid", m_valid, 1);
    check("t1_data", m_data, 64'h13121110);
    check("t1_last", m_last, 0);
    cycle(1'b0, '0);
    check("t1_gone", m_valid, 0);
    check("t1_idle", busy_out, 0);

    // FP add mode: three unskewed rows, one per cycle, latency one.
    mode_sel_in = 2'b11;
    cycle(1'b1, mk(8'h20));
    check("t2_a_v", m_valid, 1);
    check("t2_a", m_data, 64'h23222120);
    cycle(1'b1, mk(8'h24));
    check("t2_b", m_data, 64'h27262524);
    cycle(1'b1, mk(8'h28));
    check("t2_c_v", m_valid, 1);
    check("t2_c", m_data, 64'h2B2A2928);
    cycle(1'b0, '0);
    check("t2_end", m_valid, 0);

    // Full FIFO with simultaneous read and write: nothing dropped.
    do_clr();
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) cycle(1'b1, mk(8'h40 + 8'(i * 4)));
    check("t4_pre_ovf", ovf_err, 0);
    m_ready = 1'b1;
    cycle(1'b1, mk(8'h40 + 8'(9 * 4)));
    check("t4_ovf", ovf_err, 0);
    for (int i = 2; i <= 9; i++) begin
      check("t4_v", m_valid, 1);
      check("t4_d", m_data, 64'(mk(8'h40 + 8'(i * 4))));
      cycle(1'b0, '0);
    end
    check("t4_empty", m_valid, 0);
    check("t4_ovf_end", ovf_err, 0);

    // m_last on beats 4 and 8 of 10, counter wraps after each tile.
    do_clr();
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b1, mk(8'hC0 + 8'(k * 4)));
      check("t5_v", m_valid, 1);
      check($sformatf("t5_last_%0d", k), m_last, (k == 4 || k == 8) ? 1 : 0);
    end
    cycle(1'b0, '0);
    check("t5_end", m_valid, 0);

    // Backpressure and overflow: ninth row dropped, first eight intact.
    m_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      cycle(1'b1, mk(8'h80 + 8'(i * 4)));
      if (i == 8) check("t3_ovf_at8", ovf_err, 0);
    end
    check("t3_ovf", ovf_err, 1);
    check("t3_hold", m_data, 64'h87868584);
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("t3_v", m_valid, 1);
      check("t3_d", m_data, 64'(mk(8'h80 + 8'(i * 4))));
      cycle(1'b0, '0);
    end
    check("t3_empty", m_valid, 0);
    check("t3_sticky", ovf_err, 1);
    check("t3_idle", busy_out, 0);
`ifdef TAPU_DRAIN_DROP_CNT_EN
    check("t3_drop_cnt", drop_cnt_out, 1);
`endif

    // clr_in with three rows queued and two still in the deskew pipe.
    mode_sel_in = 2'b00;
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) cycle(1'b1, mk(8'h50 + 8'(i * 4)));
    cycle(1'b0, '0);
    check("t6_queued", m_valid, 1);
    do_clr();
    check("t6_v", m_valid, 0);
    check("t6_busy", busy_out, 0);
    check("t6_ovf", ovf_err, 0);
`ifdef TAPU_DRAIN_DROP_CNT_EN
    check("t6_drop_cnt", drop_cnt_out, 0);
`endif
    m_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, '0);
      if (m_valid) seen++;
    end
    check("t6_no_rows", seen, 0);

    // Same again, discarded by an rst_n pulse off the clock edge.
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) cycle(1'b1, mk(8'h60 + 8'(i * 4)));
    cycle(1'b0, '0);
    check("t6r_queued", busy_out, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6r_v", m_valid, 0);
    check("t6r_busy", busy_out, 0);
    @(posedge clk);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, '0);
      if (m_valid || busy_out) seen++;
    end
    check("t6r_no_rows", seen, 0);
    check("t6r_ovf", ovf_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
